// File: rtl/periph_bus_pkg.sv
// Shared types and constants for the 16-bit peripheral bus initiator.
package periph_bus_pkg;

  localparam int ADDR_W      = 8;
  localparam int DATA_W      = 16;
  localparam int TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STROBE  = 2'd1,
    RECOVER = 2'd2,
    RESP    = 2'd3
  } state_t;

  // Unstrobed byte lanes read back as zero.
  function automatic logic [DATA_W-1:0] lane_mask(input logic [DATA_W-1:0] d,
                                                  input logic u, input logic l);
    return {(u ? d[15:8] : 8'h00), (l ? d[7:0] : 8'h00)};
  endfunction

endpackage

// File: rtl/periph_bus_master.sv
// Peripheral bus initiator: one word or a 32-bit long (two bus cycles, MSW first)
// per command, with a per-cycle ack timeout and a single response pulse.
//
// state   | meaning
// IDLE    | cmd_ready high, strobes low, rw = 1
// STROBE  | address/data/strobes held, waiting for ack or timeout
// RECOVER | one strobes-low cycle; ack ignored; launches second word of a long
// RESP    | rsp_valid pulse
module periph_bus_master
  import periph_bus_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_rw,
  input  logic        cmd_long,
  input  logic [7:0]  cmd_addr,
  input  logic [1:0]  cmd_be,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [7:0]  addr,
  output logic [15:0] data_write,
  input  logic [15:0] data_read,
  output logic        uds,
  output logic        lds,
  output logic        rw,
  input  logic        ack
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               is_long, second, err;
  logic [31:0]        rd_acc;
  logic [15:0]        wdata_lo;
  logic               tmo_hit, cmd_empty, more;
  logic [DATA_W-1:0]  lanes;

  assign tmo_hit   = (cnt == CNT_W'(TIMEOUT));
  assign cmd_empty = !cmd_long && (cmd_be == 2'b00);
  assign more      = is_long && !second && !err;
  assign lanes     = lane_mask(data_read, uds, lds);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_valid) state_nxt = cmd_empty ? RESP : STROBE;
      STROBE:  if (ack || tmo_hit) state_nxt = RECOVER;
      RECOVER: state_nxt = more ? STROBE : RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state == IDLE);
    rsp_valid = (state == RESP);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt        <= '0;
      is_long    <= 1'b0;
      second     <= 1'b0;
      err        <= 1'b0;
      rd_acc     <= '0;
      wdata_lo   <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      addr       <= '0;
      data_write <= '0;
      uds        <= 1'b0;
      lds        <= 1'b0;
      rw         <= 1'b1;
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          is_long  <= cmd_long;
          second   <= 1'b0;
          cnt      <= '0;
          rd_acc   <= '0;
          wdata_lo <= cmd_wdata[15:0];
          if (cmd_empty) begin
            err       <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end else begin
            err        <= 1'b0;
            addr       <= cmd_addr & 8'hFE;
            rw         <= cmd_rw;
            data_write <= cmd_long ? cmd_wdata[31:16] : cmd_wdata[15:0];
            uds        <= cmd_long | cmd_be[1];
            lds        <= cmd_long | cmd_be[0];
          end
        end
        STROBE: begin
          if (ack) begin
            uds <= 1'b0;
            lds <= 1'b0;
            if (is_long && !second) rd_acc[31:16] <= lanes;
            else                    rd_acc[15:0]  <= lanes;
          end else if (tmo_hit) begin
            uds <= 1'b0;
            lds <= 1'b0;
            err <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RECOVER: begin
          if (more) begin
            addr       <= addr + 8'd2;
            data_write <= wdata_lo;
            uds        <= 1'b1;
            lds        <= 1'b1;
            second     <= 1'b1;
            cnt        <= '0;
          end else begin
            rsp_err   <= err;
            rsp_rdata <= (err || !rw) ? 32'd0 : rd_acc;
          end
        end
        RESP: rw <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_periph_bus_master.sv
// Randomized bench for periph_bus_master against a word-addressed memory model.
module tb_periph_bus_master;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid, cmd_ready, cmd_rw, cmd_long;
  logic [7:0]  cmd_addr;
  logic [1:0]  cmd_be;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [7:0]  addr;
  logic [15:0] data_write, data_read;
  logic        uds, lds, rw, ack;

  int checks = 0;
  int failures = 0;

  periph_bus_master #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw), .cmd_long(cmd_long),
    .cmd_addr(cmd_addr), .cmd_be(cmd_be), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .addr(addr), .data_write(data_write), .data_read(data_read),
    .uds(uds), .lds(lds), .rw(rw), .ack(ack)
  );

  always #5 clk = ~clk;

  // Responder: registered ack after rsp_dly strobe cycles, held while strobes were seen.
  int          rsp_dly = 1;
  logic        rsp_en = 1'b1;
  int          scnt;
  logic [15:0] mem [128];

  assign data_read = mem[addr[7:1]];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scnt <= 0;
      ack  <= 1'b0;
      for (int i = 0; i < 128; i++) mem[i] <= 16'h0;
    end else if (uds || lds) begin
      scnt <= scnt + 1;
      ack  <= rsp_en && (scnt + 1 >= rsp_dly);
      if (ack && !rw) begin
        if (uds) mem[addr[7:1]][15:8] <= data_write[15:8];
        if (lds) mem[addr[7:1]][7:0]  <= data_write[7:0];
      end
    end else begin
      scnt <= 0;
      ack  <= 1'b0;
    end
  end

  typedef struct {
    logic [7:0]  a;
    logic [15:0] d;
    logic        u, l, r;
    int          len;
    logic        stable;
    int          gap;
  } burst_t;

  burst_t bursts[$];

  initial begin : monitor
    burst_t cur;
    logic prev;
    int low_cnt;
    prev = 1'b0;
    low_cnt = 0;
    cur = '{a: 8'h0, d: 16'h0, u: 1'b0, l: 1'b0, r: 1'b0, len: 0, stable: 1'b0, gap: 0};
    forever begin
      @(negedge clk);
      if (uds || lds) begin
        if (!prev) begin
          cur = '{a: addr, d: data_write, u: uds, l: lds, r: rw, len: 1, stable: 1'b1, gap: low_cnt};
        end else begin
          cur.len++;
          if (addr !== cur.a || data_write !== cur.d || uds !== cur.u || lds !== cur.l || rw !== cur.r)
            cur.stable = 1'b0;
        end
        prev = 1'b1;
      end else begin
        if (prev) bursts.push_back(cur);
        low_cnt = prev ? 1 : low_cnt + 1;
        prev = 1'b0;
      end
    end
  end

  logic [15:0] ref_mem [128];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic run_cmd(input logic r, input logic lg, input logic [7:0] a, input logic [1:0] be,
                         input logic [31:0] wd, input int d, input logic en);
    logic [7:0]  ea [2];
    logic [15:0] ed [2];
    logic [15:0] w0, w1;
    logic [31:0] erd;
    logic        eu, el, eerr;
    int          nb, elen, elat, k;

    ea[0] = a & 8'hFE;
    ea[1] = ea[0] + 8'd2;
    ed[0] = lg ? wd[31:16] : wd[15:0];
    ed[1] = wd[15:0];
    eu = lg | be[1];
    el = lg | be[0];
    erd = 32'd0;
    eerr = 1'b0;
    elen = 0;
    if (!lg && be == 2'b00) begin
      nb = 0; eerr = 1'b1; elat = 0;
    end else if (!en) begin
      nb = 1; eerr = 1'b1; elen = TMO + 1; elat = TMO + 2;
    end else begin
      nb = lg ? 2 : 1;
      elen = d + 1;
      elat = nb * (d + 2);
      w0 = ref_mem[ea[0][7:1]];
      w1 = ref_mem[ea[1][7:1]];
      if (r) begin
        erd = lg ? {w0, w1} : {16'd0, (eu ? w0[15:8] : 8'h00), (el ? w0[7:0] : 8'h00)};
      end else if (lg) begin
        ref_mem[ea[0][7:1]] = wd[31:16];
        ref_mem[ea[1][7:1]] = wd[15:0];
      end else begin
        if (be[1]) ref_mem[ea[0][7:1]][15:8] = wd[15:8];
        if (be[0]) ref_mem[ea[0][7:1]][7:0]  = wd[7:0];
      end
    end

    rsp_dly = d;
    rsp_en = en;
    k = 0;
    while (!cmd_ready && k < 50) begin @(negedge clk); k++; end
    check_val("idle_ready", {31'd0, cmd_ready}, 32'd1);
    check_val("idle_rw", {31'd0, rw}, 32'd1);
    bursts.delete();
    cmd_valid = 1'b1; cmd_rw = r; cmd_long = lg; cmd_addr = a; cmd_be = be; cmd_wdata = wd;
    @(negedge clk);
    cmd_valid = 1'b0;
    k = 0;
    while (!rsp_valid && k < 200) begin @(negedge clk); k++; end
    if (!rsp_valid) begin
      check_val("rsp_wait_expired", 32'd0, 32'd1);
    end else begin
      check_val("latency", k, elat);
      check_val("rsp_rdata", rsp_rdata, erd);
      check_val("rsp_err", {31'd0, rsp_err}, {31'd0, eerr});
    end
    @(negedge clk);
    check_val("rsp_pulse", {31'd0, rsp_valid}, 32'd0);
    check_val("ready_back", {31'd0, cmd_ready}, 32'd1);
    check_val("n_bus_cycles", bursts.size(), nb);
    for (int i = 0; i < nb && i < bursts.size(); i++) begin
      check_val("bus_addr", {24'd0, bursts[i].a}, {24'd0, ea[i]});
      check_val("bus_wdata", {16'd0, bursts[i].d}, {16'd0, ed[i]});
      check_val("bus_strobes", {30'd0, bursts[i].u, bursts[i].l}, {30'd0, eu, el});
      check_val("bus_rw", {31'd0, bursts[i].r}, {31'd0, r});
      check_val("strobe_len", bursts[i].len, elen);
      check_val("bus_stable", {31'd0, bursts[i].stable}, 32'd1);
      if (i == 1) check_val("recover_gap", bursts[i].gap, 32'd1);
    end
  endtask

  initial begin
    int seen;
    for (int i = 0; i < 128; i++) ref_mem[i] = 16'h0;
    reset_n = 1'b0;
    cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_long = 1'b0;
    cmd_addr = 8'h0; cmd_be = 2'b00; cmd_wdata = 32'h0;
    repeat (3) @(negedge clk);
    check_val("rst_outputs",
              {22'd0, cmd_ready, rsp_valid, rsp_err, uds, lds, rw, (rsp_rdata != 0), (addr != 0),
               (data_write != 0), 1'b0},
              {22'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    reset_n = 1'b1;
    @(negedge clk);

    run_cmd(1'b0, 1'b0, 8'h00, 2'b11, 32'h0000_1234, 1, 1'b1);
    run_cmd(1'b1, 1'b0, 8'h00, 2'b11, 32'h0000_0000, 1, 1'b1);
    run_cmd(1'b0, 1'b1, 8'h04, 2'b00, 32'hDEAD_BEEF, 1, 1'b1);
    run_cmd(1'b1, 1'b1, 8'h04, 2'b11, 32'h0, 2, 1'b1);
    run_cmd(1'b0, 1'b1, 8'hFE, 2'b11, 32'hCAFE_F00D, 1, 1'b1);
    run_cmd(1'b1, 1'b1, 8'hFF, 2'b00, 32'h0, 1, 1'b1);
    run_cmd(1'b0, 1'b0, 8'h21, 2'b01, 32'h0000_AB55, 1, 1'b1);
    run_cmd(1'b0, 1'b0, 8'h30, 2'b11, 32'h0000_7788, 1, 1'b1);
    run_cmd(1'b1, 1'b0, 8'h30, 2'b10, 32'h0, 1, 1'b1);
    run_cmd(1'b1, 1'b0, 8'h00, 2'b11, 32'h0, 4, 1'b1);
    run_cmd(1'b1, 1'b0, 8'h00, 2'b11, 32'h0, 1, 1'b0);
    run_cmd(1'b0, 1'b1, 8'h40, 2'b11, 32'h1111_2222, 1, 1'b0);
    run_cmd(1'b1, 1'b0, 8'h50, 2'b00, 32'h0, 1, 1'b1);

    // Reset in the middle of a long read: command dropped, no response.
    rsp_dly = 2; rsp_en = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_long = 1'b1; cmd_addr = 8'h10; cmd_be = 2'b11;
    @(negedge clk);
    cmd_valid = 1'b0;
    check_val("pre_rst_strobing", {30'd0, uds, lds}, 32'd3);
    #2 reset_n = 1'b0;
    #1;
    check_val("rst_mid_strobes", {30'd0, uds, lds}, 32'd0);
    check_val("rst_mid_rw", {31'd0, rw}, 32'd1);
    check_val("rst_mid_ready", {31'd0, cmd_ready}, 32'd1);
    check_val("rst_mid_addr", {24'd0, addr}, 32'd0);
    seen = 0;
    for (int i = 0; i < 3; i++) begin @(negedge clk); if (rsp_valid) seen++; end
    for (int i = 0; i < 128; i++) ref_mem[i] = 16'h0;
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin @(negedge clk); if (rsp_valid) seen++; end
    check_val("no_rsp_after_rst", seen, 32'd0);
    run_cmd(1'b0, 1'b1, 8'h10, 2'b11, 32'h5A5A_A5A5, 1, 1'b1);
    run_cmd(1'b1, 1'b1, 8'h10, 2'b11, 32'h0, 3, 1'b1);

    for (int n = 0; n < 40; n++) begin
      run_cmd(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
              2'($urandom_range(0, 3)), $urandom, int'($urandom_range(1, 4)),
              ($urandom_range(0, 9) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/periph_bus_master.md
# periph_bus_master

Bus initiator for the 16-bit peripheral bus (addr/uds/lds/rw/ack) used by the timer and other memory-mapped peripherals. Accepts single word or 32-bit long commands on a valid/ready port. Runs one or two 16-bit bus cycles with a per-cycle ack timeout, then returns read data and an error flag. Sits between an internal controller (debug/DMA logic) and the peripheral bus; the peripherals are responders.

## Interface
- `TIMEOUT`, 255: maximum cycles a strobe stays asserted without ack before abort (≥ 2).
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset; one clock domain.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  high only in IDLE; transfer on `cmd_valid && cmd_ready`.
- `cmd_rw`  in  1  1 = read, 0 = write.
- `cmd_long`  in  1  1 = 32-bit transfer (two bus cycles).
- `cmd_addr`  in  8  byte address; bit 0 ignored.
- `cmd_be`  in  2  word only: [1] → uds (high byte), [0] → lds; ignored when long.
- `cmd_wdata`  in  32  word uses [15:0]; long: [31:16] first cycle, [15:0] second.
- `rsp_valid`  out  1  one-cycle pulse per command.
- `rsp_rdata`  out  32  read result; 0 for writes and errors.
- `rsp_err`  out  1  timeout or empty byte enables; valid with `rsp_valid`.
- `addr`  out  8  bus address, bit 0 always 0.
- `data_write`  out  16  bus write data.
- `data_read`  in  16  bus read data, valid in cycles where `ack` = 1.
- `uds`, `lds`  out  1 each  byte strobes.
- `rw`  out  1  bus direction, 1 = read.
- `ack`  in  1  responder acknowledge (registered in responder, ≥1 cycle after strobes).

## Operation
- States: IDLE, STROBE, RECOVER, RESP.
- IDLE: cmd_ready = 1, strobes 0, rw = 1. On accept: latch command; word with cmd_be = 0 → RESP with err = 1, no bus cycle; else drive addr/rw/data_write/strobes → STROBE.
- STROBE: addr, rw, data_write, strobes held stable. Timeout counter counts from 0 each cycle. On sampled ack: capture data_read lanes (unstrobed lanes → 0), drop strobes → RECOVER. On count = TIMEOUT with no ack: drop strobes, err = 1, discard pending second word → RECOVER.
- RECOVER: exactly one cycle with strobes low; ack ignored (responders hold ack one extra cycle). If long, first word done, no error: addr ← addr + 2 (mod 256), data_write ← cmd_wdata[15:0], uds = lds = 1 → STROBE. Else → RESP.
- RESP: rsp_valid = 1 for one cycle → IDLE.
- Long read: rsp_rdata = {first word, second word} (big-endian; lower address = MSW). Word read: {16'd0, lanes}.
- Each bus cycle sees strobes high ≥ 2 cycles; repeated responder writes are idempotent by design.
- Reset values: cmd_ready 1, rsp_valid 0, rsp_rdata 0, rsp_err 0, addr 0, data_write 0, uds 0, lds 0, rw 1, state IDLE, counter 0.
- Reset asserted mid-transfer: all outputs take reset values immediately (async); the command is dropped with no response.

## Timing
- Accept at edge E0; strobes high after E0. With a 1-cycle-ack responder: ack high after E1, sampled E2; strobes low after E2 (RECOVER).
- Word: RESP/rsp_valid high after E3; cmd_ready high after E4.
- Long: second strobe after E3, ack sampled E5, RECOVER after E5, rsp_valid after E6, cmd_ready after E7.
- Empty be: rsp_valid (err) high after E0, cmd_ready after E1.
- Timeout: strobes high for TIMEOUT+1 cycles, then RECOVER, then RESP.
- Back-to-back commands: at most one command per 4 cycles (word).
- Counter width: $clog2(TIMEOUT+1); it never wraps (saturates at abort).

## Structure
- Package `periph_bus_pkg`: state enum (IDLE, STROBE, RECOVER, RESP), default TIMEOUT constant, bus width constants (ADDR_W = 8, DATA_W = 16).
- Single module; no sub-module required.

## Test plan
- Word read addr 0x00, be = 2'b11, responder returns 0x1234 with 1-cycle ack -> rsp_rdata = 0x00001234, err = 0, rsp_valid after E3, uds/lds high exactly 2 cycles.
- Long write addr 0x04, wdata 0xDEADBEEF -> bus cycles addr 0x04 data 0xDEAD then 0x06 data 0xBEEF, one low-strobe cycle between, rsp err = 0.
- Long read addr 0xFE -> second cycle addr 0x00 (wrap); rsp_rdata = {word@0xFE, word@0x00}.
- Word write be = 2'b01 data 0xAB55 -> only lds high, data_write = 0xAB55; word read be = 2'b10 returning 0x7788 -> rsp_rdata = 0x00007700.
- No ack, TIMEOUT = 4 -> strobes high 5 cycles, rsp_err = 1, rsp_rdata = 0; long with first-cycle timeout -> no second cycle; word with be = 0 -> err after E0, no strobe.
- reset_n low during STROBE of a long read -> strobes 0 and rw = 1 immediately, no rsp_valid; next command after release completes normally.
